xeng_acc_serializer: RTL and testbench

XENG_ACC_SERIALIZER -- requirements
Module: xeng_acc_serializer

---
 rtl/xeng_acc_serializer.sv | 213 +++++++++++++++++++++
 tb/tb_xeng_acc_serializer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xeng_acc_serializer.sv
// rtl/xeng_acc_serializer.sv - buffers X-engine accumulation words and serializes them one Stokes term per beat
module xeng_acc_serializer #(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int P_FACTOR_BITS       = 2,
    parameter int BITWIDTH            = 4,
    parameter int N_ANTS              = 32,
    parameter int FIFO_DEPTH_BITS     = 4,
    localparam int WORD_W    = (2 * BITWIDTH + 1) + P_FACTOR_BITS + SERIAL_ACC_LEN_BITS,
    localparam int ACC_WIDTH = 8 * WORD_W,
    localparam int BASELINES = N_ANTS * ((N_ANTS >> 1) + 1),
    localparam int BL_W      = $clog2(BASELINES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  sync_in,
    input  logic [ACC_WIDTH-1:0]  acc_in,
    input  logic                  valid_in,
    output logic [2*WORD_W-1:0]   dout,
    output logic [1:0]            dout_stokes,
    output logic [BL_W-1:0]       dout_baseline,
    output logic                  dout_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overflow
);

    localparam int SW      = 2 * WORD_W;
    localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
    localparam int ENTRY_W = ACC_WIDTH + BL_W;

    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BASELINES - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // ce exists only so the block drops into the Simulink-generated wrapper unchanged
    logic unused_ce;
    assign unused_ce = ce;

    // ------------------------------------------------------------------
    // Baseline tagging
    // ------------------------------------------------------------------
    logic [BL_W-1:0] bl_cnt;
    logic [BL_W-1:0] tag_in;
    logic [BL_W-1:0] bl_inc;

    // A frame sync re-origins the count so a word arriving with it is baseline 0
    always_comb begin
        tag_in = sync_in ? '0 : bl_cnt;
        bl_inc = (tag_in == BL_LAST) ? '0 : tag_in + BL_W'(1);
    end

    // Counter advances on every valid word, including ones the FIFO has to drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_cnt <= '0;
        end else if (valid_in) begin
            bl_cnt <= bl_inc;
        end else if (sync_in) begin
            bl_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO holding {accumulation, baseline tag}
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]         mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   fifo_cnt;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic [ENTRY_W-1:0]         rd_entry;
    logic [ACC_WIDTH-1:0]       rd_acc;
    logic [BL_W-1:0]            rd_tag;

    logic [0:0]                 state;
    logic [1:0]                 beat;

    assign fifo_full  = fifo_cnt[FIFO_DEPTH_BITS];
    assign fifo_empty = (fifo_cnt == '0);
    assign rd_entry   = mem[rd_ptr];
    assign rd_acc     = rd_entry[ENTRY_W-1:BL_W];
    assign rd_tag     = rd_entry[BL_W-1:0];

    // Pop whenever the serializer is free for a new word: idle, or finishing its YX beat
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE) begin
                pop = 1'b1;
            end else if (dout_ready && (beat == 2'd3)) begin
                pop = 1'b1;
            end
        end
    end

    // A full FIFO still accepts a word if a slot frees up in the same cycle
    assign push = valid_in && (!fifo_full || pop);

    // Storage array carries no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {acc_in, tag_in};
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (FIFO_DEPTH_BITS + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (FIFO_DEPTH_BITS + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky drop flag; a drop in the sync cycle itself still counts against the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (valid_in && !push) begin
            overflow <= 1'b1;
        end else if (sync_in) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    logic [ACC_WIDTH-1:0] word_acc;
    logic [BL_W-1:0]      word_tag;
    logic [SW-1:0]        slices [4];
    logic [1:0]           next_beat;

    for (genvar k = 0; k < 4; k++) begin : g_slice
        assign slices[k] = word_acc[k*SW +: SW];
    end

    assign next_beat   = beat + 2'd1;
    assign dout_stokes = beat;

    // Outputs are registered and only move on an accepted beat, so they hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat          <= 2'd0;
            word_acc      <= '0;
            word_tag      <= '0;
            dout          <= '0;
            dout_baseline <= '0;
            dout_last     <= 1'b0;
            dout_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state         <= SHIFT;
                        beat          <= 2'd0;
                        word_acc      <= rd_acc;
                        word_tag      <= rd_tag;
                        dout          <= rd_acc[SW-1:0];
                        dout_baseline <= rd_tag;
                        dout_last     <= 1'b0;
                        dout_valid    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (dout_ready) begin
                        if (beat == 2'd3) begin
                            if (pop) begin
                                beat          <= 2'd0;
                                word_acc      <= rd_acc;
                                word_tag      <= rd_tag;
                                dout          <= rd_acc[SW-1:0];
                                dout_baseline <= rd_tag;
                                dout_last     <= 1'b0;
                            end else begin
                                state      <= IDLE;
                                dout_valid <= 1'b0;
                                dout_last  <= 1'b0;
                            end
                        end else begin
                            beat      <= next_beat;
                            dout      <= slices[next_beat];
                            dout_last <= (word_tag == BL_LAST) && (next_beat == 2'd3);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xeng_acc_serializer.sv
// tb/tb_xeng_acc_serializer.sv - self-checking bench for xeng_acc_serializer
module tb_xeng_acc_serializer;

    localparam int SW    = 36;
    localparam int ACC_W = 144;
    localparam int BLS   = 544;
    localparam int BL_W  = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             ce = 1'b1;
    logic             sync_in = 1'b0;
    logic             valid_in = 1'b0;
    logic             dout_ready = 1'b0;
    logic [ACC_W-1:0] acc_in = '0;
    logic [SW-1:0]    dout;
    logic [1:0]       dout_stokes;
    logic [BL_W-1:0]  dout_baseline;
    logic             dout_last;
    logic             dout_valid;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int last_cnt = 0;
    int bl_model = 0;

    typedef struct {
        logic [SW-1:0]   d;
        logic [1:0]      s;
        logic [BL_W-1:0] b;
        logic            l;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    xeng_acc_serializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .sync_in       (sync_in),
        .acc_in        (acc_in),
        .valid_in      (valid_in),
        .dout          (dout),
        .dout_stokes   (dout_stokes),
        .dout_baseline (dout_baseline),
        .dout_last     (dout_last),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .overflow      (overflow)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] rnd_acc();
        logic [ACC_W-1:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r = {r[ACC_W-33:0], 32'($urandom)};
        end
        return r;
    endfunction

    // One cycle of stimulus; the model tags the word and queues its four expected beats
    task automatic drive(input logic v, input logic s, input logic [ACC_W-1:0] d, input logic drop);
        int    tag;
        beat_t e;
        valid_in = v;
        sync_in  = s;
        acc_in   = d;
        if (v) begin
            tag = s ? 0 : bl_model;
            if (!drop) begin
                for (int k = 0; k < 4; k++) begin
                    e.d = d[k*SW +: SW];
                    e.s = 2'(k);
                    e.b = BL_W'(tag);
                    e.l = (tag == BLS - 1) && (k == 3);
                    exp_q.push_back(e);
                end
            end
            bl_model = (tag + 1) % BLS;
        end else if (s) begin
            bl_model = 0;
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sync_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Keeps at most 15 words outstanding so the FIFO can never fill
    task automatic send_gated(input logic s);
        int guard;
        guard = 0;
        while (exp_q.size() > 60 && guard < 200) begin
            idle(1);
            guard++;
        end
        drive(1'b1, s, rnd_acc(), 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    // Output monitor: every accepted beat against the model, and stability under backpressure
    logic            prev_stall = 1'b0;
    logic [SW-1:0]   h_d;
    logic [1:0]      h_s;
    logic [BL_W-1:0] h_b;
    logic            h_l;

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", dout_valid, 1'b1);
                chk("hold_data", dout, h_d);
                chk("hold_stokes", dout_stokes, h_s);
                chk("hold_baseline", dout_baseline, h_b);
                chk("hold_last", dout_last, h_l);
            end
            if (dout_valid && dout_ready) begin
                if (dout_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", dout_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", dout, e.d);
                    chk("beat_stokes", dout_stokes, e.s);
                    chk("beat_baseline", dout_baseline, e.b);
                    chk("beat_last", dout_last, e.l);
                end
            end
            prev_stall = dout_valid && !dout_ready;
            h_d = dout;
            h_s = dout_stokes;
            h_b = dout_baseline;
            h_l = dout_last;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ACC_W-1:0] a;
        logic             found;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_dout", dout, '0);
        chk("rst_stokes", dout_stokes, 2'd0);
        chk("rst_baseline", dout_baseline, '0);
        chk("rst_last", dout_last, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, latency and beat order
        dout_ready = 1'b1;
        a = {36'd4, 36'd3, 36'd2, 36'd1};
        drive(1'b1, 1'b0, a, 1'b0);
        chk("lat_n1_valid", dout_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_n2_valid", dout_valid, 1'b1);
        chk("lat_n2_dout", dout, 36'd1);
        chk("lat_n2_stokes", dout_stokes, 2'd0);
        chk("lat_n2_baseline", dout_baseline, 10'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("lat_n5_dout", dout, 36'd4);
        chk("lat_n5_stokes", dout_stokes, 2'd3);
        @(posedge clk);
        #1;
        chk("lat_n6_valid", dout_valid, 1'b0);
        drain();

        // Backpressure for 10 cycles mid-word
        drive(1'b1, 1'b0, rnd_acc(), 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (dout_valid && dout_stokes == 2'd1) found = 1'b1;
            else idle(1);
        end
        chk("stall_reach_beat1", found, 1'b1);
        dout_ready = 1'b0;
        idle(10);
        chk("stall_stokes", dout_stokes, 2'd1);
        dout_ready = 1'b1;
        drain();

        // Full baseline sweep after sync
        drive(1'b0, 1'b1, '0, 1'b0);
        last_cnt = 0;
        for (int i = 0; i < BLS + 1; i++) send_gated(1'b0);
        drain();
        chk("sweep_last_count", last_cnt, 1);

        // Overflow: one word held in the serializer, 16 fill the FIFO, the 17th drops
        dout_ready = 1'b0;
        drive(1'b1, 1'b0, rnd_acc(), 1'b0);
        idle(2);
        for (int i = 1; i <= 17; i++) begin
            if (i == 17) chk("ovf_before_drop", overflow, 1'b0);
            drive(1'b1, 1'b0, rnd_acc(), i == 17);
        end
        chk("ovf_set", overflow, 1'b1);
        idle(3);
        chk("ovf_sticky", overflow, 1'b1);
        dout_ready = 1'b1;
        drain();

        // 100 words, then sync with a word in the same cycle
        for (int i = 0; i < 100; i++) send_gated(1'b0);
        drain();
        chk("ovf_still_set", overflow, 1'b1);
        drive(1'b1, 1'b1, rnd_acc(), 1'b0);
        chk("sync_clears_ovf", overflow, 1'b0);
        send_gated(1'b0);
        drain();

        // Randomized traffic with backpressure and occasional syncs
        for (int i = 0; i < 600; i++) begin
            dout_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 2) == 0) && (exp_q.size() <= 60),
                  ($urandom_range(0, 99) == 0), rnd_acc(), 1'b0);
        end
        dout_ready = 1'b1;
        drain();
        chk("rand_no_ovf", overflow, 1'b0);

        // Reset during beat 2 with three words queued
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, rnd_acc(), 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (dout_valid && dout_stokes == 2'd2) found = 1'b1;
            else idle(1);
        end
        chk("rst_reach_beat2", found, 1'b1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        bl_model = 0;
        #1;
        chk("midrst_valid", dout_valid, 1'b0);
        chk("midrst_dout", dout, '0);
        chk("midrst_baseline", dout_baseline, '0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(20);
        chk("postrst_quiet", dout_valid, 1'b0);
        drive(1'b1, 1'b0, rnd_acc(), 1'b0);
        drain();
        chk("postrst_ovf", overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
